// File: rtl/fa_pkg.sv
// Shared definitions for the ripple-carry adder family.
package fa_pkg;

    // Widest operand a full_adder instance may be built with.
    localparam int FA_MAX_WIDTH = 64;

    // {carry, sum} result as handed between wider arithmetic blocks.
    typedef struct packed {
        logic                    carry;
        logic [FA_MAX_WIDTH-1:0] sum;
    } fa_result_t;

    // Packs a carry and a sum into the shared result struct.
    function automatic fa_result_t fa_pack(input logic carry, input logic [FA_MAX_WIDTH-1:0] sum);
        fa_result_t r;
        r.carry = carry;
        r.sum   = sum;
        return r;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder, the basic cell of the ripple chain.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Propagate term is shared between the sum and the carry-out.
    logic prop;

    // Sum is the parity of the three inputs; carry is generate or propagated carry-in.
    always_comb begin
        prop = a ^ b;
        s    = prop ^ ci;
        co   = (a & b) | (ci & prop);
    end

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from fa_cell, with an optional
// output register stage. With REG_OUT=0 clk and rst_n are ignored.
module full_adder
    import fa_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic [WIDTH-1:0] s,
    output logic             Cout
);

    // Widths outside the supported range are rejected at elaboration.
    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
        $error("full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
    end

    // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = Cin;

    // Ripple chain: each cell's carry-out feeds the next cell's carry-in.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum_comb[i]),
            .co (carry[i+1])
        );
    end

    if (REG_OUT) begin : g_reg
        // Capture the ripple result every cycle; reset clears it asynchronously.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s    <= '0;
                Cout <= 1'b0;
            end else begin
                s    <= sum_comb;
                Cout <= carry[WIDTH];
            end
        end
    end else begin : g_comb
        // Clock and reset have no role in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};

        assign s    = sum_comb;
        assign Cout = carry[WIDTH];
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a 1-bit and a 4-bit combinational build
// plus an 8-bit registered build, all driven from the same operand bus.
module tb_full_adder;

    logic       clk;
    logic       rst_n;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_cin;

    logic       s1;
    logic       cout1;
    logic [3:0] s4;
    logic       cout4;
    logic [7:0] s8;
    logic       cout8;

    int vectors     = 0;
    int miscompares = 0;

    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (op_a[0]),
        .b    (op_b[0]),
        .Cin  (op_cin),
        .s    (s1),
        .Cout (cout1)
    );

    full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (op_a[3:0]),
        .b    (op_b[3:0]),
        .Cin  (op_cin),
        .s    (s4),
        .Cout (cout4)
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (op_a),
        .b    (op_b),
        .Cin  (op_cin),
        .s    (s8),
        .Cout (cout8)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin);
        op_a   = a;
        op_b   = b;
        op_cin = cin;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed 1-bit truth table indexed by {a,b,Cin}.
    logic [7:0] sum_tab  = 8'b1001_0110;
    logic [7:0] cout_tab = 8'b1110_1000;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       cout;
    } vec8_t;

    vec8_t b2b[4];

    initial begin
        logic [2:0] idx;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        logic [4:0] exp5;

        b2b[0] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
        b2b[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        b2b[2] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};
        b2b[3] = '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1};

        $display("[TB] start");
        rst_n = 1'b0;
        applyStimulus(8'h00, 8'h00, 1'b0);
        #2;
        checkOutput("reset_s8", 64'(s8), 64'h0);
        checkOutput("reset_cout8", 64'(cout8), 64'h0);
        afterEdge();
        checkOutput("reset_hold_s8", 64'(s8), 64'h0);
        #2;
        rst_n = 1'b1;

        // 1-bit exhaustive truth table, one vector every 50 ns.
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            applyStimulus({7'h0, idx[2]}, {7'h0, idx[1]}, idx[0]);
            #50;
            checkOutput($sformatf("tt%0d_s", i), 64'(s1), 64'(sum_tab[idx]));
            checkOutput($sformatf("tt%0d_cout", i), 64'(cout1), 64'(cout_tab[idx]));
        end

        // 4-bit directed corners.
        applyStimulus(8'h0F, 8'h00, 1'b1);
        #1;
        checkOutput("w4_F_0_1_s", 64'(s4), 64'h0);
        checkOutput("w4_F_0_1_cout", 64'(cout4), 64'h1);
        applyStimulus(8'h05, 8'h03, 1'b0);
        #1;
        checkOutput("w4_5_3_0_s", 64'(s4), 64'h8);
        checkOutput("w4_5_3_0_cout", 64'(cout4), 64'h0);
        applyStimulus(8'h0F, 8'h0F, 1'b1);
        #1;
        checkOutput("w4_F_F_1_s", 64'(s4), 64'hF);
        checkOutput("w4_F_F_1_cout", 64'(cout4), 64'h1);

        // 4-bit random sweep against a 5-bit reference sum.
        for (int i = 0; i < 10000; i++) begin
            ra   = 4'($urandom);
            rb   = 4'($urandom);
            rc   = 1'($urandom);
            exp5 = 5'(ra) + 5'(rb) + 5'(rc);
            applyStimulus({4'h0, ra}, {4'h0, rb}, rc);
            #1;
            checkOutput("w4_rand", 64'({cout4, s4}), 64'(exp5));
        end

        // Registered 8-bit: result appears only after the next rising edge.
        #2;
        applyStimulus(8'h01, 8'h01, 1'b0);
        afterEdge();
        checkOutput("w8_pre_s", 64'(s8), 64'h02);
        applyStimulus(8'h80, 8'h80, 1'b0);
        #2;
        checkOutput("w8_before_edge_s", 64'(s8), 64'h02);
        checkOutput("w8_before_edge_cout", 64'(cout8), 64'h0);
        afterEdge();
        checkOutput("w8_after_edge_s", 64'(s8), 64'h00);
        checkOutput("w8_after_edge_cout", 64'(cout8), 64'h1);

        // Back-to-back vectors, each visible exactly one edge later.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(b2b[i].a, b2b[i].b, b2b[i].cin);
            #2;
            checkOutput($sformatf("b2b%0d_lag_cout", i), 64'(cout8),
                        64'((i == 0) ? 1'b1 : b2b[i-1].cout));
            afterEdge();
            checkOutput($sformatf("b2b%0d_s", i), 64'(s8), 64'(b2b[i].s));
            checkOutput($sformatf("b2b%0d_cout", i), 64'(cout8), 64'(b2b[i].cout));
        end

        // Mid-cycle asynchronous reset while the output shows 0xAB.
        applyStimulus(8'hA0, 8'h0B, 1'b0);
        afterEdge();
        checkOutput("rst_pre_s", 64'(s8), 64'hAB);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_s", 64'(s8), 64'h0);
        checkOutput("rst_async_cout", 64'(cout8), 64'h0);
        applyStimulus(8'h12, 8'h34, 1'b1);
        for (int i = 0; i < 3; i++) begin
            afterEdge();
            checkOutput($sformatf("rst_hold%0d_s", i), 64'(s8), 64'h0);
            checkOutput($sformatf("rst_hold%0d_cout", i), 64'(cout8), 64'h0);
        end
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_release_s", 64'(s8), 64'h0);
        afterEdge();
        checkOutput("rst_first_s", 64'(s8), 64'h47);
        checkOutput("rst_first_cout", 64'(cout8), 64'h0);

        // Combinational 1-bit ignores clock and reset activity.
        applyStimulus(8'h01, 8'h00, 1'b1);
        #1;
        for (int i = 0; i < 4; i++) begin
            rst_n = ~rst_n;
            #3;
            checkOutput($sformatf("w1_ign%0d_s", i), 64'(s1), 64'h0);
            checkOutput($sformatf("w1_ign%0d_cout", i), 64'(cout1), 64'h1);
            afterEdge();
            checkOutput($sformatf("w1_ign%0d_edge_cout", i), 64'(cout1), 64'h1);
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
